count_enable_gen: RTL and testbench

COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

---
 rtl/count_enable_gen_pkg.sv | 17 +
 rtl/count_enable_gen_key_debounce.sv | 70 +++++++
 rtl/count_enable_gen.sv | 88 ++++++++
 tb/tb_count_enable_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/count_enable_gen_pkg.sv
// Shared definitions for the count enable generator: FSM encodings and debounce defaults.
package count_enable_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

   // Width of a counter that must hold values 0..n-1 (n >= 2).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/count_enable_gen_key_debounce.sv
// Raw key conditioning: 2-flop synchronizer, stable-level debouncer and rising-edge press pulse.
// After clear the key is disarmed: it must first be seen released for a full debounce
// window, so a key held through clear never produces a press.
module key_debounce
   import count_enable_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic clear,
   input  logic key_raw,
   output logic pressed
);

   localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic             ref_level;
   logic             differ;
   logic             accept;

   // Bring the asynchronous key into the clock domain.
   always_ff @(posedge clock) begin
      if (clear) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // While disarmed the reference is forced high, so only a stable release is counted.
   always_comb begin
      ref_level = armed ? level : 1'b1;
      differ    = (sync2 != ref_level);
      accept    = differ && (cnt == CNT_LAST);
   end

   // Count consecutive samples that disagree with the reference; accept after a full window.
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt     <= '0;
         level   <= 1'b0;
         armed   <= 1'b0;
         pressed <= 1'b0;
      end else begin
         pressed <= 1'b0;
         if (!differ) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= '0;
            if (armed) begin
               level   <= sync2;
               pressed <= sync2;
            end else begin
               armed <= 1'b1;
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/count_enable_gen.sv
// Run/stop/single-step controller producing a registered enable pulse for a counter chain.
module count_enable_gen
   import count_enable_gen_pkg::*;
#(
   parameter int unsigned PRESCALE_W      = 26,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  key_run,
   input  logic                  key_step,
   input  logic [PRESCALE_W-1:0] divisor,
   output logic                  enable,
   output logic                  running,
   output logic [1:0]            state
);

   state_t                state_q;
   state_t                state_d;
   logic                  run_press;
   logic                  step_press;
   logic [PRESCALE_W-1:0] count;
   logic [PRESCALE_W-1:0] last;
   logic                  tick;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
      .clock   (clock),
      .clear   (clear),
      .key_raw (key_run),
      .pressed (run_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
      .clock   (clock),
      .clear   (clear),
      .key_raw (key_step),
      .pressed (step_press)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; run press has priority over step press in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (run_press)       state_d = RUN;
            else if (step_press) state_d = STEP;
         end
         RUN: begin
            if (run_press) state_d = IDLE;
         end
         STEP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Terminal count is D-1 with D = max(divisor,1); >= catches a divisor lowered mid-run.
   always_comb begin
      last = (divisor == '0) ? '0 : divisor - PRESCALE_W'(1);
      tick = (state_q == RUN) && (state_d == RUN) && (count >= last);
   end

   // Prescaler and registered enable pulse.
   always_ff @(posedge clock) begin
      if (clear) begin
         count  <= '0;
         enable <= 1'b0;
      end else begin
         enable <= tick || (state_q == STEP);
         if ((state_q != RUN) && (state_d == RUN)) begin
            count <= '0;
         end else if (tick) begin
            count <= '0;
         end else if ((state_q == RUN) && (state_d == RUN)) begin
            count <= count + PRESCALE_W'(1);
         end
      end
   end

   assign running = (state_q == RUN);
   assign state   = state_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed self-checking bench for count_enable_gen (PRESCALE_W = 8, DEBOUNCE_CYCLES = 4).
module tb_count_enable_gen;

   logic       clock    = 1'b0;
   logic       clear    = 1'b1;
   logic       key_run  = 1'b0;
   logic       key_step = 1'b0;
   logic [7:0] divisor  = 8'd5;
   logic       enable;
   logic       running;
   logic [1:0] state;

   int   n_checks    = 0;
   int   n_errors    = 0;
   int   run_entries = 0;
   int   entries0;
   logic prev_running = 1'b0;
   logic [31:0] en_v;
   logic [31:0] st_v;

   count_enable_gen #(.PRESCALE_W(8), .DEBOUNCE_CYCLES(4)) dut (
      .clock    (clock),
      .clear    (clear),
      .key_run  (key_run),
      .key_step (key_step),
      .divisor  (divisor),
      .enable   (enable),
      .running  (running),
      .state    (state)
   );

   always #5 clock = ~clock;

   // Count entries into RUN.
   always @(posedge clock) begin
      if (running && !prev_running) run_entries++;
      prev_running <= running;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit i of en_v/st_v = enable / (state==STEP) sampled after the (i+1)-th edge.
   task automatic sample(input int n, output logic [31:0] ev, output logic [31:0] sv);
      ev = '0;
      sv = '0;
      for (int i = 0; i < n; i++) begin
         cycles(1);
         ev[i] = enable;
         sv[i] = (state == 2'd2);
      end
   endtask

   initial begin
      // Reset held 3 cycles with run key pressed
      key_run = 1'b1;
      clear   = 1'b1;
      cycles(3);
      chk("reset_enable",  32'(enable),  32'd0);
      chk("reset_running", 32'(running), 32'd0);
      chk("reset_state",   32'(state),   32'd0);
      clear = 1'b0;
      cycles(20);
      chk("held_after_reset_running", 32'(running), 32'd0);
      chk("held_after_reset_entries", 32'(run_entries), 32'd0);
      key_run = 1'b0;
      cycles(10);

      // Clean run press, divisor 5
      divisor = 8'd5;
      key_run = 1'b1;
      cycles(6);
      chk("run_not_before_pulse", 32'(running), 32'd0);
      cycles(1);
      chk("run_entered", 32'(running), 32'd1);
      chk("run_state",   32'(state),   32'd1);
      key_run = 1'b0;
      sample(15, en_v, st_v);
      chk("run_spacing_5", en_v, 32'h0000_4210);

      // Second press stops; only the pulse already in flight appears
      key_run = 1'b1;
      sample(20, en_v, st_v);
      chk("stop_enable",  en_v,          32'h0000_0010);
      chk("stop_running", 32'(running),  32'd0);
      chk("stop_state",   32'(state),    32'd0);
      key_run = 1'b0;
      cycles(10);

      // Step in IDLE: one pulse, state 0 -> 2 -> 0
      key_step = 1'b1;
      sample(12, en_v, st_v);
      chk("step_enable",    en_v,        32'h0000_0080);
      chk("step_state_seq", st_v,        32'h0000_0040);
      chk("step_back_idle", 32'(state),  32'd0);
      key_step = 1'b0;
      cycles(10);

      // Step press while running does not disturb spacing
      key_run = 1'b1;
      cycles(7);
      chk("run2_entered", 32'(running), 32'd1);
      key_run  = 1'b0;
      key_step = 1'b1;
      sample(20, en_v, st_v);
      chk("step_in_run_spacing", en_v,         32'h0008_4210);
      chk("step_in_run_state",   32'(state),   32'd1);
      key_step = 1'b0;
      cycles(10);

      // Divisor 1 and 0: enable every cycle
      divisor = 8'd1;
      sample(8, en_v, st_v);
      chk("div1_every_cycle", en_v, 32'h0000_00FF);
      divisor = 8'd0;
      sample(8, en_v, st_v);
      chk("div0_every_cycle", en_v, 32'h0000_00FF);

      // Divisor 200 -> 3 at count 100
      divisor = 8'd200;
      cycles(100);
      chk("div200_quiet", 32'(enable), 32'd0);
      divisor = 8'd3;
      sample(8, en_v, st_v);
      chk("div_shrink_spacing", en_v, 32'h0000_0049);

      key_run = 1'b1;
      cycles(12);
      chk("stop2_running", 32'(running), 32'd0);
      key_run = 1'b0;
      cycles(10);

      // Bouncing run key then held: exactly one entry into RUN
      entries0 = run_entries;
      for (int i = 0; i < 10; i++) begin
         key_run = ~key_run;
         cycles(2);
      end
      key_run = 1'b1;
      cycles(15);
      chk("bounce_running", 32'(running), 32'd1);
      chk("bounce_entries", 32'(run_entries - entries0), 32'd1);
      key_run = 1'b0;
      cycles(10);
      key_run = 1'b1;
      cycles(12);
      chk("stop3_running", 32'(running), 32'd0);
      key_run = 1'b0;
      cycles(10);

      // Simultaneous presses in IDLE: RUN wins, no step pulse
      divisor  = 8'd200;
      key_run  = 1'b1;
      key_step = 1'b1;
      sample(12, en_v, st_v);
      chk("simul_enable",  en_v,         32'd0);
      chk("simul_no_step", st_v,         32'd0);
      chk("simul_running", 32'(running), 32'd1);
      key_run  = 1'b0;
      key_step = 1'b0;
      cycles(10);

      // Clear mid-run with run key held through release
      divisor = 8'd1;
      cycles(3);
      chk("midrun_enable", 32'(enable), 32'd1);
      key_run = 1'b1;
      clear   = 1'b1;
      cycles(1);
      chk("clear_enable", 32'(enable), 32'd0);
      chk("clear_state",  32'(state),  32'd0);
      cycles(2);
      clear = 1'b0;
      cycles(20);
      chk("held_through_clear_running", 32'(running), 32'd0);
      chk("held_through_clear_enable",  32'(enable),  32'd0);
      key_run = 1'b0;
      cycles(10);
      key_run = 1'b1;
      cycles(7);
      chk("repress_after_clear", 32'(running), 32'd1);
      key_run = 1'b0;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
